// File: rtl/mod_transition_ctl.sv
// mod_transition_ctl
//   Chooses which waveform segment (0/1) the sampler reads. It also decides
//   when a requested segment change takes effect, and counts segment loops
//   so that a finite segment can stop.
//
// Ports
//   CLK               system clock
//   RST               synchronous active-high reset
//   UPDATE            one-cycle strobe that latches a new segment request
//   REQ_RD_SEGMENT    requested segment
//   TRANSITION_MODE   00 sync-to-loop-end, 01 system time, 02 gpio, FF immediate
//   TRANSITION_VALUE  time threshold (mode 01) or gpio bit index in [1:0] (mode 02)
//   REP0, REP1        loop count minus one per segment (REP_INFINITE = forever)
//   SYS_TIME          monotonic system time
//   GPIO_IN           external trigger inputs
//   LOOP_END          pulse from the sampler when the active segment wraps
//   SEGMENT           active read segment
//   STOP              active segment has played all of its loops
//   BUSY              a request is pending
//   SWITCHED          pulse on the cycle after a commit
//   ERR               pulse on the cycle after an UPDATE with an unsupported mode
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no request pending
// WAIT_IDX  | commit on next LOOP_END (or at once if stopped)
// WAIT_TIME | commit once SYS_TIME >= latched value
// WAIT_GPIO | commit on rising edge of the selected GPIO bit
module mod_transition_ctl #(
  parameter logic [31:0] REP_INFINITE = 32'hFFFF_FFFF,
  parameter int          GPIO_W       = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UPDATE,
  input  logic              REQ_RD_SEGMENT,
  input  logic [7:0]        TRANSITION_MODE,
  input  logic [63:0]       TRANSITION_VALUE,
  input  logic [31:0]       REP0,
  input  logic [31:0]       REP1,
  input  logic [63:0]       SYS_TIME,
  input  logic [GPIO_W-1:0] GPIO_IN,
  input  logic              LOOP_END,
  output logic              SEGMENT,
  output logic              STOP,
  output logic              BUSY,
  output logic              SWITCHED,
  output logic              ERR
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IDX  = 2'd1,
    WAIT_TIME = 2'd2,
    WAIT_GPIO = 2'd3
  } state_t;

  localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0] MODE_GPIO      = 8'h02;
  localparam logic [7:0] MODE_IMMEDIATE = 8'hFF;

  state_t            state, state_n;
  logic              segment, segment_n;
  logic              stop, stop_n;
  logic              switched_n, err_n;
  logic              seg_req, seg_req_n;
  logic [63:0]       value_l, value_n;
  logic [31:0]       cnt, cnt_n;
  logic [GPIO_W-1:0] gpio_d;
  logic [31:0]       rep_cur;
  logic              gpio_rise;
  logic              mode_ok, cond, commit;

  assign rep_cur   = segment ? REP1 : REP0;
  assign gpio_rise = GPIO_IN[value_l[1:0]] & ~gpio_d[value_l[1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      segment  <= 1'b0;
      stop     <= 1'b0;
      SWITCHED <= 1'b0;
      ERR      <= 1'b0;
      seg_req  <= 1'b0;
      value_l  <= '0;
      cnt      <= '0;
      gpio_d   <= '0;
    end else begin
      state    <= state_n;
      segment  <= segment_n;
      stop     <= stop_n;
      SWITCHED <= switched_n;
      ERR      <= err_n;
      seg_req  <= seg_req_n;
      value_l  <= value_n;
      cnt      <= cnt_n;
      gpio_d   <= GPIO_IN;
    end
  end

  always_comb begin
    state_n    = state;
    segment_n  = segment;
    stop_n     = stop;
    switched_n = 1'b0;
    err_n      = 1'b0;
    seg_req_n  = seg_req;
    value_n    = value_l;
    cnt_n      = cnt;
    commit     = 1'b0;

    mode_ok = (TRANSITION_MODE == MODE_SYNC_IDX) || (TRANSITION_MODE == MODE_SYS_TIME) ||
              (TRANSITION_MODE == MODE_GPIO)     || (TRANSITION_MODE == MODE_IMMEDIATE);

    case (state)
      WAIT_IDX:  cond = LOOP_END | stop;
      WAIT_TIME: cond = (SYS_TIME >= value_l);
      WAIT_GPIO: cond = gpio_rise;
      default:   cond = 1'b0;
    endcase

    // Loop accounting; a commit on this same edge overrides it below.
    if (LOOP_END && !stop) begin
      if ((rep_cur != REP_INFINITE) && (cnt >= rep_cur)) begin
        stop_n = 1'b1;
      end else if (cnt != '1) begin
        cnt_n = cnt + 32'd1;
      end
    end

    if (UPDATE && !mode_ok) begin
      err_n = 1'b1;
    end

    // A valid UPDATE replaces whatever is pending, even if that request's
    // condition is met on this edge.
    if (UPDATE && mode_ok) begin
      seg_req_n = REQ_RD_SEGMENT;
      value_n   = TRANSITION_VALUE;
      case (TRANSITION_MODE)
        MODE_SYNC_IDX: state_n = WAIT_IDX;
        MODE_SYS_TIME: state_n = WAIT_TIME;
        MODE_GPIO:     state_n = WAIT_GPIO;
        default: begin
          state_n   = IDLE;
          segment_n = REQ_RD_SEGMENT;
          commit    = 1'b1;
        end
      endcase
    end else if (cond) begin
      state_n   = IDLE;
      segment_n = seg_req;
      commit    = 1'b1;
    end

    if (commit) begin
      switched_n = 1'b1;
      stop_n     = 1'b0;
      cnt_n      = '0;
    end
  end

  assign SEGMENT = segment;
  assign STOP    = stop;
  assign BUSY    = (state != IDLE);

endmodule

// File: doc/mod_transition_ctl.md
MOD_TRANSITION_CTL -- requirements
Module: mod_transition_ctl

Interface
REQ-001 Parameters: REP_INFINITE, 32'hFFFF_FFFF, REP value meaning loop forever; GPIO_W, 4, width of GPIO_IN.
REQ-002 CLK  in  1  system clock; single clock domain for all logic.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 UPDATE  in  1  one-cycle strobe; latches a new segment request.
REQ-005 REQ_RD_SEGMENT  in  1  requested segment (0/1).
REQ-006 TRANSITION_MODE  in  8  transition condition code.
REQ-007 TRANSITION_VALUE  in  64  mode-dependent operand.
REQ-008 REP0, REP1  in  32 each  loop count per segment; loops played = REP+1.
REQ-009 SYS_TIME  in  64  synchronized system time, monotonic.
REQ-010 GPIO_IN  in  GPIO_W  external trigger inputs.
REQ-011 LOOP_END  in  1  one-cycle pulse from sampler when active segment index wraps CYCLE->0.
REQ-012 SEGMENT  out  1  active read segment.
REQ-013 STOP  out  1  active segment finished its finite loops; sampler holds last sample.
REQ-014 BUSY  out  1  request pending (WAIT state).
REQ-015 SWITCHED  out  1  one-cycle pulse on the cycle SEGMENT changes or restarts.
REQ-016 ERR  out  1  one-cycle pulse on unsupported TRANSITION_MODE.

Function
REQ-017 Mode codes SHALL be: 8'h00 SYNC_IDX, 8'h01 SYS_TIME, 8'h02 GPIO, 8'hFF IMMEDIATE; any other code SHALL discard the request, pulse ERR the cycle after UPDATE, and leave state unchanged.
REQ-018 FSM states SHALL be IDLE, WAIT_IDX, WAIT_TIME, WAIT_GPIO; BUSY=1 exactly in WAIT_*.
REQ-019 On UPDATE sampled at edge N, request fields SHALL latch at N; IMMEDIATE SHALL commit the switch at N (SEGMENT, SWITCHED visible cycle N+1); other modes enter WAIT_* at N.
REQ-020 WAIT_IDX SHALL commit at the edge sampling LOOP_END=1; if STOP=1 on entry, commit at the first WAIT edge.
REQ-021 WAIT_TIME SHALL commit at the first edge sampling SYS_TIME >= TRANSITION_VALUE (unsigned 64-bit); a past time commits at the first WAIT edge.
REQ-022 WAIT_GPIO SHALL commit on rising edge of GPIO_IN[TRANSITION_VALUE[1:0]], detected with a one-cycle-delayed register; level high at entry is not an edge.
REQ-023 Commit SHALL: set SEGMENT=latched segment, pulse SWITCHED, clear STOP, clear loop counter, return to IDLE.
REQ-024 Request for the already-active segment SHALL be honoured as a restart (same commit actions).
REQ-025 Loop counter (32-bit) SHALL increment on LOOP_END in IDLE or WAIT when STOP=0; when count reaches REP[SEGMENT] (i.e. REP+1th LOOP_END) and REP!=REP_INFINITE, STOP SHALL assert next cycle and hold; counter SHALL not wrap.
REQ-026 LOOP_END coincident with WAIT_IDX commit SHALL NOT count toward the new segment.
REQ-027 UPDATE during WAIT_* SHALL replace the pending request (latest wins); UPDATE coincident with a commit condition SHALL take priority, old request discarded, no SWITCHED.
REQ-028 REP0/REP1 changes SHALL take effect on the next comparison; no latch.

Reset
REQ-029 RST=1 at any edge SHALL force IDLE, SEGMENT=0, STOP=0, BUSY=0, SWITCHED=0, ERR=0, loop counter=0, GPIO edge register=0, discarding any pending request; RST dominates UPDATE.

Verification
REQ-030 UPDATE, REQ=1, MODE=FF -> SEGMENT=1 and SWITCHED=1 next cycle, BUSY never 1.
REQ-031 MODE=00, REQ=1, LOOP_END 20 cycles later -> BUSY 1 for 20 cycles, SEGMENT=1 the cycle after LOOP_END, loop counter 0.
REQ-032 MODE=01, VALUE=1000, SYS_TIME ramps from 990 -> switch visible the cycle after SYS_TIME=1000 sampled; repeat with VALUE=500 -> switch visible 2 cycles after UPDATE.
REQ-033 REP0=2, three LOOP_END pulses -> STOP=1 after third; fourth LOOP_END ignored; then MODE=00 request -> immediate commit, STOP=0.
REQ-034 MODE=02, VALUE=1, GPIO_IN[1] held high at UPDATE, falls, rises -> commit only on rise; second UPDATE MODE=07 -> ERR pulse, no state change.
REQ-035 RST asserted while in WAIT_TIME with SEGMENT=1, STOP=1 -> next cycle all outputs 0, later SYS_TIME match causes no switch.
